// File: rtl/user_tx_arbiter.sv
// user_tx_arbiter: packet-level round-robin share of one 64-bit AXI-stream TX port
// between two sources, with a programmable idle gap after every packet.
`timescale 1ns/1ps
module user_tx_arbiter #(
    parameter int P_GAP   = 4,
    parameter int P_CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [63:0]        s0_axi_tx_tdata,
    input  logic [7:0]         s0_axi_tx_tkeep,
    input  logic               s0_axi_tx_tlast,
    input  logic               s0_axi_tx_tvalid,
    output logic               s0_axi_tx_tready,
    input  logic [63:0]        s1_axi_tx_tdata,
    input  logic [7:0]         s1_axi_tx_tkeep,
    input  logic               s1_axi_tx_tlast,
    input  logic               s1_axi_tx_tvalid,
    output logic               s1_axi_tx_tready,
    output logic [63:0]        m_axi_tx_tdata,
    output logic [7:0]         m_axi_tx_tkeep,
    output logic               m_axi_tx_tlast,
    output logic               m_axi_tx_tvalid,
    input  logic               m_axi_tx_tready,
    output logic [1:0]         o_grant,
    output logic [P_CNT_W-1:0] o_pkt_cnt0,
    output logic [P_CNT_W-1:0] o_pkt_cnt1
);

    localparam int GAP_LD = (P_GAP > 0) ? P_GAP - 1 : 0;
    localparam int GAP_W  = (GAP_LD > 0) ? $clog2(GAP_LD + 1) : 1;
    localparam logic [GAP_W-1:0]   GAP_INIT = GAP_LD[GAP_W-1:0];
    localparam logic [GAP_W-1:0]   GAP_ONE  = 1;
    localparam logic [P_CNT_W-1:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sel;
    logic               w_sel_nxt;
    logic               r_last;
    logic [GAP_W-1:0]   r_gap;
    logic [P_CNT_W-1:0] r_cnt0;
    logic [P_CNT_W-1:0] r_cnt1;
    logic               w_busy;
    logic               w_eop;

    assign w_busy = (r_state == BUSY);
    assign w_eop  = w_busy & m_axi_tx_tvalid & m_axi_tx_tready & m_axi_tx_tlast;

    // r_sel only changes on an IDLE grant, so a packet can never be interleaved
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        unique case (r_state)
            IDLE: begin
                if (s0_axi_tx_tvalid || s1_axi_tx_tvalid) begin
                    w_state_nxt = BUSY;
                    w_sel_nxt   = (s0_axi_tx_tvalid && s1_axi_tx_tvalid)
                                  ? ~r_last : s1_axi_tx_tvalid;
                end
            end
            BUSY: begin
                if (w_eop) begin
                    w_state_nxt = (P_GAP > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axi_tx_tdata   = '0;
        m_axi_tx_tkeep   = '0;
        m_axi_tx_tlast   = 1'b0;
        m_axi_tx_tvalid  = 1'b0;
        s0_axi_tx_tready = 1'b0;
        s1_axi_tx_tready = 1'b0;
        o_grant          = 2'b00;
        if (w_busy) begin
            if (r_sel) begin
                m_axi_tx_tdata   = s1_axi_tx_tdata;
                m_axi_tx_tkeep   = s1_axi_tx_tkeep;
                m_axi_tx_tlast   = s1_axi_tx_tlast;
                m_axi_tx_tvalid  = s1_axi_tx_tvalid;
                s1_axi_tx_tready = m_axi_tx_tready;
                o_grant          = 2'b10;
            end else begin
                m_axi_tx_tdata   = s0_axi_tx_tdata;
                m_axi_tx_tkeep   = s0_axi_tx_tkeep;
                m_axi_tx_tlast   = s0_axi_tx_tlast;
                m_axi_tx_tvalid  = s0_axi_tx_tvalid;
                s0_axi_tx_tready = m_axi_tx_tready;
                o_grant          = 2'b01;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_gap   <= '0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            if (w_eop) begin
                r_last <= r_sel;
                r_gap  <= GAP_INIT;
                if (r_sel) begin
                    r_cnt1 <= r_cnt1 + CNT_ONE;
                end else begin
                    r_cnt0 <= r_cnt0 + CNT_ONE;
                end
            end else if (r_state == GAP && r_gap != '0) begin
                r_gap <= r_gap - GAP_ONE;
            end
        end
    end

    assign o_pkt_cnt0 = r_cnt0;
    assign o_pkt_cnt1 = r_cnt1;

endmodule

// File: tb/tb_user_tx_arbiter.sv
// tb_user_tx_arbiter: randomized scoreboard bench for user_tx_arbiter;
// per-source expected beat queues are popped by an output monitor.
`timescale 1ns/1ps
module tb_user_tx_arbiter;

    localparam int GAP = 4;
    localparam int CW  = 8;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [63:0]   s0_tdata = '0, s1_tdata = '0;
    logic [7:0]    s0_tkeep = '0, s1_tkeep = '0;
    logic          s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic          s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic          s0_tready, s1_tready;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep;
    logic          m_tlast, m_tvalid;
    logic          m_tready = 1'b1;
    logic [1:0]    o_grant;
    logic [CW-1:0] o_cnt0, o_cnt1;

    user_tx_arbiter #(.P_GAP(GAP), .P_CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .s0_axi_tx_tdata(s0_tdata), .s0_axi_tx_tkeep(s0_tkeep),
        .s0_axi_tx_tlast(s0_tlast), .s0_axi_tx_tvalid(s0_tvalid),
        .s0_axi_tx_tready(s0_tready),
        .s1_axi_tx_tdata(s1_tdata), .s1_axi_tx_tkeep(s1_tkeep),
        .s1_axi_tx_tlast(s1_tlast), .s1_axi_tx_tvalid(s1_tvalid),
        .s1_axi_tx_tready(s1_tready),
        .m_axi_tx_tdata(m_tdata), .m_axi_tx_tkeep(m_tkeep),
        .m_axi_tx_tlast(m_tlast), .m_axi_tx_tvalid(m_tvalid),
        .m_axi_tx_tready(m_tready),
        .o_grant(o_grant), .o_pkt_cnt0(o_cnt0), .o_pkt_cnt1(o_cnt1)
    );

    always #5 clk = ~clk;

    int      n_chk = 0;
    int      n_err = 0;
    beat_t   sq[2][$];
    beat_t   eq[2][$];
    int      ord[$];
    bit      bp_en = 0, bub_en = 0, rr_strict = 0;
    int      phase_id = 0;
    // reference model state
    bit      in_pkt = 0;
    int      cur_src = 0;
    int      mlast = 1;
    logic [CW-1:0] mcnt[2];

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int s, input int len, input bit seq);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.d = seq ? 64'(i) : {$urandom, $urandom};
            b.d[63] = s[0];
            b.k = seq ? 8'hFF : 8'($urandom);
            b.l = (i == len - 1);
            sq[s].push_back(b);
            eq[s].push_back(b);
        end
    endtask

    task automatic flush();
        for (int s = 0; s < 2; s++) begin
            sq[s].delete();
            eq[s].delete();
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((eq[0].size() != 0 || eq[1].size() != 0 || in_pkt) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(n < budget, "drain_timeout", 64'(n), 64'(budget));
        if (n >= budget) flush();
        repeat (GAP + 4) @(posedge clk);
        #2;
    endtask

    // source drivers and PHY backpressure
    initial begin
        bit hs0, hs1;
        forever begin
            @(negedge clk);
            hs0 = s0_tvalid && s0_tready;
            hs1 = s1_tvalid && s1_tready;
            @(posedge clk);
            #1;
            if (hs0 && sq[0].size() > 0) void'(sq[0].pop_front());
            if (hs1 && sq[1].size() > 0) void'(sq[1].pop_front());
            s0_tvalid = sq[0].size() > 0 && (!bub_en || ($urandom % 4) != 0);
            s1_tvalid = sq[1].size() > 0 && (!bub_en || ($urandom % 4) != 0);
            if (sq[0].size() > 0) begin
                s0_tdata = sq[0][0].d; s0_tkeep = sq[0][0].k; s0_tlast = sq[0][0].l;
            end else begin
                s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0;
            end
            if (sq[1].size() > 0) begin
                s1_tdata = sq[1][0].d; s1_tkeep = sq[1][0].k; s1_tlast = sq[1][0].l;
            end else begin
                s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0;
            end
            m_tready = !bp_en || ($urandom % 3) != 0;
        end
    end

    // output monitor / scoreboard
    initial begin
        int cyc = 0, tl_cyc = -1, seen_phase = 0, s;
        bit cnt_chk = 0;
        beat_t e;
        logic [1:0] g;
        mcnt[0] = '0;
        mcnt[1] = '0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                in_pkt = 0; mlast = 1; mcnt[0] = '0; mcnt[1] = '0;
                tl_cyc = -1; cnt_chk = 0;
            end else begin
                cyc++;
                if (seen_phase != phase_id) begin
                    seen_phase = phase_id;
                    tl_cyc = -1;
                end
                if (cnt_chk) begin
                    chk(o_cnt0 == mcnt[0] && o_cnt1 == mcnt[1] && o_grant == 2'b00,
                        "pkt_cnt", {o_grant, 8'h0, o_cnt1, 8'h0, o_cnt0},
                        {2'b00, 8'h0, mcnt[1], 8'h0, mcnt[0]});
                    cnt_chk = 0;
                end
                if (tl_cyc >= 0 && cyc - tl_cyc >= 1 && cyc - tl_cyc <= GAP + 1)
                    chk(!m_tvalid && !s0_tready && !s1_tready, "gap_quiet",
                        {m_tvalid, s0_tready, s1_tready}, 0);
                if (in_pkt)
                    chk((cur_src == 0 ? s1_tready : s0_tready) == 1'b0, "other_ready",
                        1, 0);
                if (m_tvalid && m_tready) begin
                    s = int'(m_tdata[63]);
                    if (!in_pkt) begin
                        if (rr_strict && eq[0].size() > 0 && eq[1].size() > 0)
                            chk(s == 1 - mlast, "rr_pick", 64'(s), 64'(1 - mlast));
                        if (tl_cyc >= 0) begin
                            if (rr_strict)
                                chk(cyc - tl_cyc == GAP + 2, "gap_len",
                                    64'(cyc - tl_cyc), 64'(GAP + 2));
                            else
                                chk(cyc - tl_cyc >= GAP + 2, "gap_min",
                                    64'(cyc - tl_cyc), 64'(GAP + 2));
                        end
                        in_pkt = 1;
                        cur_src = s;
                    end else if (s != cur_src) begin
                        chk(0, "interleave", 64'(s), 64'(cur_src));
                    end
                    if (eq[s].size() == 0) begin
                        chk(0, "unexpected_beat", m_tdata, 0);
                    end else begin
                        e = eq[s].pop_front();
                        g = (s == 1) ? 2'b10 : 2'b01;
                        chk(m_tdata == e.d && m_tkeep == e.k && m_tlast == e.l && o_grant == g,
                            "beat", m_tdata ^ {m_tkeep, 53'h0, m_tlast, o_grant},
                            e.d ^ {e.k, 53'h0, e.l, g});
                    end
                    if (m_tlast) begin
                        in_pkt = 0;
                        mlast = s;
                        mcnt[s] = mcnt[s] + 1'b1;
                        cnt_chk = 1;
                        tl_cyc = cyc;
                        ord.push_back(s);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin
        int idx, n;
        logic [CW-1:0] c0, c1;
        repeat (3) @(posedge clk);
        #2 i_rst = 1'b0;
        // idle after reset
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk({m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready, s1_tready, o_grant,
                 o_cnt0, o_cnt1} == '0, "reset_idle",
                {m_tvalid, s0_tready, s1_tready, o_grant, o_cnt0, o_cnt1}, 0);
        end
        // simultaneous contention, 2 packets each
        @(posedge clk); #2;
        phase_id++; rr_strict = 1; bp_en = 0; bub_en = 0;
        idx = ord.size();
        push_pkt(0, 10, 0); push_pkt(0, 10, 0);
        push_pkt(1, 10, 0); push_pkt(1, 10, 0);
        drain(1000);
        for (int i = 0; i < 4; i++)
            chk(ord.size() > idx + i && ord[idx + i] == i % 2, "contention_order",
                ord.size() > idx + i ? 64'(ord[idx + i]) : 64'hx, 64'(i % 2));
        // 100-beat sequential packet from source 0
        phase_id++; rr_strict = 0;
        c0 = mcnt[0];
        push_pkt(0, 100, 1);
        drain(1000);
        chk(o_cnt0 == c0 + 1'b1, "cnt0_after_100", 64'(o_cnt0), 64'(c0 + 1'b1));
        // random backpressure and source bubbles
        phase_id++; bp_en = 1; bub_en = 1;
        for (int i = 0; i < 8; i++) begin
            push_pkt(0, int'($urandom_range(1, 12)), 0);
            push_pkt(1, int'($urandom_range(1, 12)), 0);
        end
        drain(8000);
        // reset mid-packet
        phase_id++; bp_en = 1; bub_en = 0;
        push_pkt(0, 100, 1);
        n = 0;
        while (eq[0].size() > 50 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk(n < 2000, "reset_wait_timeout", 64'(n), 2000);
        #2 i_rst = 1'b1;
        #1;
        chk(!m_tvalid && !s0_tready && !s1_tready && o_grant == 2'b00,
            "reset_outputs", {m_tvalid, s0_tready, s1_tready, o_grant}, 0);
        chk(o_cnt0 == '0 && o_cnt1 == '0, "reset_counters", {o_cnt1, o_cnt0}, 0);
        flush();
        repeat (3) @(posedge clk);
        #2 i_rst = 1'b0;
        phase_id++; rr_strict = 1; bp_en = 0;
        idx = ord.size();
        push_pkt(1, 5, 0);
        push_pkt(0, 5, 0);
        drain(500);
        chk(ord.size() > idx && ord[idx] == 0, "post_reset_winner",
            ord.size() > idx ? 64'(ord[idx]) : 64'hx, 0);
        chk(ord.size() > idx + 1 && ord[idx + 1] == 1, "post_reset_second",
            ord.size() > idx + 1 ? 64'(ord[idx + 1]) : 64'hx, 1);
        // counter wrap on source 1
        phase_id++; rr_strict = 0; bp_en = 0;
        c0 = mcnt[0];
        c1 = mcnt[1];
        for (int i = 0; i < (1 << CW); i++) push_pkt(1, 1, 0);
        drain(20000);
        chk(o_cnt1 == c1, "cnt1_wrap", 64'(o_cnt1), 64'(c1));
        chk(o_cnt0 == c0, "cnt0_unchanged", 64'(o_cnt0), 64'(c0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
